// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

    localparam int unsigned DIV_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned NBITS_W    = 4;
    localparam int unsigned NBITS_RST  = 8;
    // Holds 16*(15+2) = 272, the longest stop window.
    localparam int unsigned STOP_W     = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } state_e;

    // Ticks allowed for the frame in flight to complete: start + data + stop bits at 16x.
    function automatic logic [STOP_W-1:0] stop_load(input logic [NBITS_W-1:0] nbits);
        return (STOP_W'(nbits) + STOP_W'(2)) << 4;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO; a push on a full FIFO is dropped unless a pop frees a slot.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata_c,
    output logic                       full_c,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              do_push;
    logic              do_pop;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign rdata_c = mem_q[rd_ptr_q];
    assign valid   = valid_q;
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && (!full_c || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer: oversampling tick, run/stop gating, RxDone capture into
// a receive FIFO with sticky overrun.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W      = DIV_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Enable,
    input  logic [DIV_W-1:0]              Divisor,
    input  logic [NBITS_W-1:0]            NBitsCfg,
    output logic                          Tick,
    output logic                          RxEn,
    output logic [NBITS_W-1:0]            NBits,
    input  logic                          RxDone,
    input  logic [DATA_W-1:0]             RxData,
    output logic [DATA_W-1:0]             Data,
    output logic                          Valid,
    input  logic                          Ready,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Overrun,
    input  logic                          ClrOverrun
);

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [NBITS_W-1:0]  nbits_q, nbits_d;
    logic [STOP_W-1:0]   stop_cnt_q, stop_cnt_d;
    logic                tick_q, tick_d;
    logic                rx_en_q, rx_en_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                sync3_q, sync3_d;
    logic                overrun_q, overrun_d;
    logic [DIV_W-1:0]    cnt_next;
    logic                rx_rise;
    logic                pop;
    logic                fifo_full;
    logic                fifo_valid;

    assign Tick    = tick_q;
    assign RxEn    = rx_en_q;
    assign NBits   = nbits_q;
    assign Valid   = fifo_valid;
    assign Overrun = overrun_q;

    // RxDone synchroniser and rising-edge detect; overrun only when a push finds no room.
    always_comb begin
        sync1_d   = RxDone;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        rx_rise   = sync2_q && !sync3_q;
        pop       = fifo_valid && Ready;
        overrun_d = (overrun_q && !ClrOverrun) || (rx_rise && fifo_full && !pop);
    end

    // Sequencer; Tick is registered one cycle ahead so it is high while the counter sits at Div-1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        nbits_d    = nbits_q;
        stop_cnt_d = stop_cnt_q;
        cnt_next   = (cnt_q == div_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
        unique case (state_q)
            ST_IDLE: begin
                stop_cnt_d = '0;
                if (Enable && (Divisor >= DIV_W'(2))) begin
                    div_d   = Divisor;
                    nbits_d = NBitsCfg;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_next;
                if (!Enable) begin
                    stop_cnt_d = stop_load(nbits_q);
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_d = cnt_next;
                if (tick_q) begin
                    stop_cnt_d = stop_cnt_q - STOP_W'(1);
                end
                if (rx_rise || (tick_q && (stop_cnt_q == STOP_W'(1))) || (stop_cnt_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end
        rx_en_d = (state_d != ST_IDLE);
        tick_d  = rx_en_d && (cnt_d == div_d - DIV_W'(1));
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            nbits_q    <= NBITS_W'(NBITS_RST);
            stop_cnt_q <= '0;
            tick_q     <= 1'b0;
            rx_en_q    <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            stop_cnt_q <= stop_cnt_d;
            tick_q     <= tick_d;
            rx_en_q    <= rx_en_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .push    (rx_rise),
        .pop     (pop),
        .wdata   (RxData),
        .rdata_c (Data),
        .full_c  (fifo_full),
        .valid   (fifo_valid),
        .count   (Count)
    );

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART RS-232 receiver. Generates the 16x oversampling Tick from a programmable divisor, gates the receiver's RxEn, latches the frame-width configuration, and buffers completed bytes in a small FIFO with a valid/ready consumer handshake and sticky overrun flag. Sits between the receiver and the host/bus logic; the receiver runs entirely off the Tick and RxEn this block provides.

## Interface
- DIV_W, 16, divisor width
- DATA_W, 8, byte width
- FIFO_DEPTH, 4, receive buffer entries (power of two)
- Clk  in  1  system clock
- Rst  in  1  asynchronous, active-high reset
- Enable  in  1  level; 1 = run receiver, 0 = stop
- Divisor  in  DIV_W  Clk cycles per Tick; sampled only in IDLE
- NBitsCfg  in  4  data bits per frame; sampled only in IDLE
- Tick  out  1  one-Clk pulse to receiver
- RxEn  out  1  receiver enable
- NBits  out  4  latched frame width to receiver
- RxDone  in  1  receiver completion (asynchronous to Clk, treated as level)
- RxData  in  DATA_W  receiver byte, stable while RxDone high
- Data  out  DATA_W  FIFO head
- Valid  out  1  FIFO not empty
- Ready  in  1  consumer accepts head
- Count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- Overrun  out  1  sticky: byte dropped on full FIFO
- ClrOverrun  in  1  clears Overrun

## Operation
- States: IDLE, RUN, STOP.
- IDLE: RxEn=0, Tick=0, tick counter=0. Enable=1 and Divisor>=2 -> latch Divisor, NBitsCfg -> RUN. Divisor<2: stay IDLE.
- RUN: RxEn=1; counter counts 0..Div-1, Tick=1 in the cycle counter==Div-1, then wraps to 0. Enable=0 -> STOP, stop counter loaded with 16*(NBits+2).
- STOP: RxEn=1, Tick continues; each Tick decrements stop counter. Detected RxDone rising edge or stop counter reaching 0 -> IDLE. Enable re-asserted in STOP has no effect until IDLE.
- RxDone path: 2-flop synchroniser, third flop for rising-edge detect; one push per rising edge, RxData captured at push.
- FIFO: push on edge detect; pop on Valid&&Ready. Data=head, combinational from storage. Pointers wrap modulo FIFO_DEPTH.
- Full and push, no pop: byte dropped, Overrun<=1, contents unchanged.
- Full, push and pop same cycle: both happen, Count unchanged, no overrun.
- Empty, push and pop: Ready ignored (Valid=0), push only.
- ClrOverrun and new overrun same cycle: Overrun stays 1.
- FIFO contents and Overrun are unaffected by Enable and state transitions; only Rst clears them.

## Timing
- Reset values: Tick=0, RxEn=0, NBits=8, Data=0, Valid=0, Count=0, Overrun=0, state IDLE, all counters 0.
- Rst asserted mid-frame: immediate return to IDLE, FIFO flushed, RxEn drops asynchronously.
- First Tick: Div Clk cycles after the edge entering RUN; period exactly Div thereafter.
- RxDone to Valid: RxDone high sampled at edge k -> push at edge k+2 -> Valid=1 after edge k+2.
- Pop: Valid&&Ready at edge n -> next entry (or Valid=0) after edge n.
- Overrun sets after the edge of the dropped push.

## Structure
- Package uart_pkg: state enum (IDLE, RUN, STOP), DIV_W/DATA_W defaults, stop-count width constant.
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop/full/empty/count; controller owns sync, edge detect, tick generator, FSM, overrun.

## Test plan
- Divisor=10, Enable=1 -> Tick pulses at cycles 10, 20, 30 after RUN entry; RxEn=1; NBits=NBitsCfg=8.
- RxDone pulse with RxData=0xA5, Ready=0 -> Valid=1 three edges later, Data=0xA5, Count=1; Ready=1 -> Valid=0 next edge.
- Five bytes 0x01..0x05, Ready=0 -> Count=4, Overrun=1, Data=0x01; drain yields 0x01..0x04; ClrOverrun -> 0.
- FIFO full, push and pop same cycle -> Count stays 4, Overrun stays 0, new byte at tail.
- Enable=0 mid-frame, NBits=8 -> STOP, RxEn held; RxDone edge -> IDLE, byte stored; without RxDone -> IDLE after 160 Ticks.
- Rst asserted in RUN with Count=2 -> all outputs at reset values same cycle; Divisor=1 with Enable=1 -> remains IDLE, no Tick.
